alu_issuer: RTL and testbench

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_issuer.sv | 151 +++++++++++++++
 tb/tb_alu_issuer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encodings, FSM state type and default width for alu_issuer
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_SAR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_SADD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - issues one command to an external combinational ALU, waits, returns the result
// Optional statistics outputs op_count/zero_count under macro ALU_ISSUER_STATS_EN.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEFAULT,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zerof,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             busy
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [15:0]      op_count,
  output logic [15:0]      zero_count
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("alu_issuer: SETTLE_CYCLES must be at least 1");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_fire;

  assign rsp_fire = (state_q == ST_RESP) && rsp_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_op_d = req_op;
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          cnt_d    = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Capture on the edge the counter reaches its last value, giving SETTLE_CYCLES of latency.
        if (cnt_q == CNT_LAST) begin
          rsp_data_d = alu_out;
          rsp_zero_d = alu_zerof;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;

`ifdef ALU_ISSUER_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] zero_count_q, zero_count_d;

  always_comb begin
    op_count_d   = op_count_q;
    zero_count_d = zero_count_q;
    if (rsp_fire) begin
      op_count_d = op_count_q + 16'd1;
      if (rsp_zero_q) begin
        zero_count_d = zero_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q   <= '0;
      zero_count_q <= '0;
    end else begin
      op_count_q   <= op_count_d;
      zero_count_q <= zero_count_d;
    end
  end

  assign op_count   = op_count_q;
  assign zero_count = zero_count_q;
`else
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_alu_issuer.sv
// tb/tb_alu_issuer.sv - directed self-checking bench for alu_issuer with a behavioural team ALU
module tb_alu_issuer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_out;
  logic        alu_zerof;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic        busy;
`ifdef ALU_ISSUER_STATS_EN
  logic [15:0] op_count, zero_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issuer #(.WIDTH(16), .SETTLE_CYCLES(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_zerof (alu_zerof),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
`ifdef ALU_ISSUER_STATS_EN
    ,
    .op_count  (op_count),
    .zero_count(zero_count)
`endif
  );

  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_SHL:  alu_out = alu_a << alu_b[3:0];
      OP_SHR:  alu_out = alu_a >> alu_b[3:0];
      OP_SAR:  alu_out = 16'($signed(alu_a) >>> alu_b[3:0]);
      OP_NAND: alu_out = ~(alu_a & alu_b);
      OP_OR:   alu_out = alu_a | alu_b;
      OP_SADD: alu_out = (alu_a << 1) + alu_b;
      default: alu_out = '0;
    endcase
    alu_zerof = (alu_out == 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
  endtask

  // One command with SETTLE_CYCLES=1: accept edge, capture edge, handshake edge.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_data, input logic exp_zero);
    issue(op, a, b);
    check({tag, "_alu_op"}, 32'(alu_op), 32'(op));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_valid_early"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_valid_clr"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
`ifdef ALU_ISSUER_STATS_EN
    check("rst_op_count", 32'(op_count), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(req_ready), 32'd1);

    run_cmd("sub", OP_SUB, 16'h0007, 16'hFFFD, 16'h000A, 1'b0);
    run_cmd("or",  OP_OR,  16'h0008, 16'h0004, 16'h000C, 1'b0);
    run_cmd("add", OP_ADD, 16'h0005, 16'hFFFB, 16'h0000, 1'b1);
`ifdef ALU_ISSUER_STATS_EN
    check("stat_op_count", 32'(op_count), 32'd3);
    check("stat_zero_count", 32'(zero_count), 32'd1);
`endif
    run_cmd("sar",  OP_SAR,  16'h8000, 16'h0001, 16'hC000, 1'b0);
    run_cmd("sadd", OP_SADD, 16'h0003, 16'h0004, 16'h000A, 1'b0);

    // Backpressure with a second command pending.
    issue(OP_NAND, 16'h00FF, 16'h0F0F);
    tick();
    req_valid = 1'b1;
    req_op    = OP_SHR;
    req_a     = 16'h8000;
    req_b     = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h0000FFF0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_alu_op", 32'(alu_op), 32'(OP_NAND));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_hs_valid", 32'(rsp_valid), 32'd0);
    check("bp_no_same_cycle", 32'(alu_op), 32'(OP_NAND));
    check("bp_hs_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp2_alu_op", 32'(alu_op), 32'(OP_SHR));
    check("bp2_alu_a", 32'(alu_a), 32'h00008000);
    tick();
    check("bp2_data", 32'(rsp_data), 32'h00000800);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp2_idle", 32'(req_ready), 32'd1);

    // Reset while in SETTLE discards the command.
    issue(OP_SHL, 16'h0001, 16'h0003);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
`ifdef ALU_ISSUER_STATS_EN
    check("mid_rst_op_count", 32'(op_count), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("mid_rel_ready", 32'(req_ready), 32'd1);
    check("mid_rel_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("mid_no_rsp", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
